instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Front end of the MIPS pipeline. Generates instruction-memory read requests from a program counter and returns fetched words with their PC to the IF/ID boundary. Its instruction and valid outputs drive the decoder's instruction and chip-enable inputs. It absorbs variable memory latency and decode back-pressure, and handles redirect/flush from branch, jal and jr resolution.

Parameters:
PC_WIDTH, 32, width of fetch addresses and PC outputs
IWIDTH, 32, instruction word width (matches `IWIDTH`)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
f_i_clk  in  1  clock, all state on rising edge
f_i_rst  in  1  reset, synchronous, active-high
f_i_stall  in  1  decode not accepting; hold current output
f_i_redirect  in  1  flush and restart fetch at f_i_redirect_pc
f_i_redirect_pc  in  PC_WIDTH  redirect target (branch/jal/jr)
f_o_imem_req  out  1  read request valid
f_o_imem_addr  out  PC_WIDTH  read address, word aligned
f_i_imem_ack  in  1  memory accepts request this cycle
f_i_imem_rvalid  in  1  read data valid
f_i_imem_rdata  in  IWIDTH  read data
f_o_ce  out  1  f_o_instr valid; drives decoder ce
f_o_instr  out  IWIDTH  fetched instruction
f_o_pc  out  PC_WIDTH  address of f_o_instr
f_o_pc_plus4  out  PC_WIDTH  f_o_pc + 4, modulo 2^PC_WIDTH

Behaviour:
- Reset (f_i_rst=1 at an edge) sets: f_o_ce=0, f_o_instr=0, f_o_pc=0, f_o_pc_plus4=4, fetch_pc=RESET_PC, outstanding=0, drop=0, skid empty. f_o_imem_req=0 during reset cycles.
- Internal state:
  - fetch_pc: next address to request.
  - req_pc: PC of the accepted, outstanding request.
  - outstanding flag and drop flag.
  - 1-entry skid buffer holding {instr, pc}.
  - Output register holding f_o_ce, f_o_instr and f_o_pc.
- Request rule: f_o_imem_req=1 when all of the following hold:
  - not in reset;
  - skid empty and not being filled this cycle;
  - no outstanding request, or the outstanding one completes this cycle (f_i_imem_rvalid=1) and drop=0.
  - f_o_imem_addr=fetch_pc. Address and req are held until ack, except on redirect.
- Request acceptance: on req&&ack, req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (wraps), outstanding<=1. At most one outstanding request at any time.
- Response handling (f_i_imem_rvalid=1 while outstanding):
  - Clears outstanding.
  - If drop=1: data discarded and drop cleared.
  - Otherwise, if the output is empty or consumed this cycle (f_o_ce=0 or f_i_stall=0) and the skid is empty: data goes to the output register with pc=req_pc.
  - Otherwise: data goes to the skid.
- rvalid with no outstanding request is ignored. This covers stale responses after reset.
- Consume: output is consumed when f_o_ce=1 and f_i_stall=0. On consume:
  - a full skid moves to the output;
  - else a non-dropped response moves to the output;
  - else f_o_ce<=0.
- Stall: while f_i_stall=1, the output register is unchanged (all of f_o_ce, f_o_instr, f_o_pc stable).
- Redirect (highest priority after reset) at edge:
  - f_o_ce<=0 and skid cleared;
  - fetch_pc<=f_i_redirect_pc;
  - if a request is outstanding, or accepted this same cycle, and not completing this cycle, drop<=1;
  - a response completing this cycle is discarded;
  - redirect overrides stall.
- Latency: ack at cycle N, rvalid at N+1 → f_o_ce=1 at N+2. With single-cycle memory and no stall: throughput 1 instruction/cycle.
- Ordering: instructions are delivered in fetch order with no loss or duplication between redirects.
- f_o_pc_plus4 is a registered copy of f_o_pc+4, updated with f_o_pc.

Test Plan:
- Reset release, RESET_PC=0, memory acks every cycle with rvalid 1 cycle later, rdata=addr|0x2000_0000 → first f_o_ce=1 two cycles after the first ack. Then f_o_pc=0,4,8,… on consecutive cycles with f_o_instr=0x2000_0000, 0x2000_0004, ….
- Hold f_i_stall=1 for 3 cycles while f_o_instr=0x2000_0008 → output stable, skid holds 0x2000_000C, req=0 while skid full. Release → 0x2000_000C then 0x2000_0010, none lost or duplicated.
- Redirect to 0x0000_0100 while a request to 0x14 is outstanding → that rvalid is discarded. Next valid output has f_o_pc=0x100, f_o_pc_plus4=0x104.
- Redirect and stall in the same cycle → f_o_ce=0 next cycle, skid empty, next fetch address 0x100.
- Assert reset with a request outstanding, deliver rvalid after reset → ignored. Fetch restarts at RESET_PC with f_o_ce=0 until that response returns.
- Redirect to 0xFFFF_FFFC → output pc 0xFFFF_FFFC with f_o_pc_plus4=0. The following fetch address is 0x0000_0000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one-at-a-time instruction memory reads from
// a sequential PC, buffers returned words through a one-entry skid so decode
// back-pressure never loses data, and flushes/restarts on redirect.
module instr_fetch_unit #(
   parameter int unsigned         PC_WIDTH = 32,
   parameter int unsigned         IWIDTH   = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                f_i_clk,
   input  logic                f_i_rst,
   input  logic                f_i_stall,
   input  logic                f_i_redirect,
   input  logic [PC_WIDTH-1:0] f_i_redirect_pc,
   output logic                f_o_imem_req,
   output logic [PC_WIDTH-1:0] f_o_imem_addr,
   input  logic                f_i_imem_ack,
   input  logic                f_i_imem_rvalid,
   input  logic [IWIDTH-1:0]   f_i_imem_rdata,
   output logic                f_o_ce,
   output logic [IWIDTH-1:0]   f_o_instr,
   output logic [PC_WIDTH-1:0] f_o_pc,
   output logic [PC_WIDTH-1:0] f_o_pc_plus4
);

   localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

   // request side state
   logic [PC_WIDTH-1:0] fetch_pc;
   logic [PC_WIDTH-1:0] req_pc;
   logic                outstanding;
   logic                drop;

   // one-entry skid buffer
   logic                skid_valid;
   logic [IWIDTH-1:0]   skid_instr;
   logic [PC_WIDTH-1:0] skid_pc;

   // output register towards decode
   logic                out_ce;
   logic [IWIDTH-1:0]   out_instr;
   logic [PC_WIDTH-1:0] out_pc;
   logic [PC_WIDTH-1:0] out_pc4;

   // per-cycle decisions
   logic                out_free;
   logic                resp;
   logic                resp_live;
   logic                resp_to_out;
   logic                skid_fill;
   logic                req;
   logic                accept;
   logic [PC_WIDTH-1:0] redirect_target;

   // Routing of responses and the request qualification. A request may only
   // be raised when the response it will produce is guaranteed a home: the
   // skid is empty and nothing is landing in it this cycle.
   always_comb begin
      out_free        = ~out_ce | ~f_i_stall;
      resp            = f_i_imem_rvalid & outstanding;
      resp_live       = resp & ~drop & ~f_i_redirect;
      resp_to_out     = resp_live & out_free & ~skid_valid;
      skid_fill       = resp_live & ~resp_to_out;
      req             = ~f_i_rst & ~skid_valid & ~skid_fill &
                        (~outstanding | (f_i_imem_rvalid & ~drop));
      accept          = req & f_i_imem_ack;
      redirect_target = {f_i_redirect_pc[PC_WIDTH-1:2], 2'b00};
   end

   // Fetch PC, outstanding-request tracking and stale-response drop flag.
   always_ff @(posedge f_i_clk) begin
      if (f_i_rst) begin
         fetch_pc    <= RESET_PC;
         req_pc      <= '0;
         outstanding <= 1'b0;
         drop        <= 1'b0;
      end else begin
         if (accept) begin
            req_pc      <= fetch_pc;
            outstanding <= 1'b1;
         end else if (resp) begin
            outstanding <= 1'b0;
         end

         if (f_i_redirect) begin
            fetch_pc <= redirect_target;
            // any request still in flight after this edge belongs to the
            // abandoned path, whether it was accepted now or earlier
            drop     <= accept | (outstanding & ~f_i_imem_rvalid);
         end else begin
            if (accept)
               fetch_pc <= fetch_pc + PC_STEP;
            if (resp && drop)
               drop <= 1'b0;
         end
      end
   end

   // Skid buffer: catches a live response that cannot enter the output.
   always_ff @(posedge f_i_clk) begin
      if (f_i_rst) begin
         skid_valid <= 1'b0;
         skid_instr <= '0;
         skid_pc    <= '0;
      end else if (f_i_redirect) begin
         skid_valid <= 1'b0;
      end else if (skid_fill) begin
         skid_valid <= 1'b1;
         skid_instr <= f_i_imem_rdata;
         skid_pc    <= req_pc;
      end else if (out_free) begin
         skid_valid <= 1'b0;
      end
   end

   // Output register: refilled from skid first, then from a live response.
   always_ff @(posedge f_i_clk) begin
      if (f_i_rst) begin
         out_ce    <= 1'b0;
         out_instr <= '0;
         out_pc    <= '0;
         out_pc4   <= PC_STEP;
      end else if (f_i_redirect) begin
         out_ce <= 1'b0;
      end else if (out_free) begin
         if (skid_valid) begin
            out_ce    <= 1'b1;
            out_instr <= skid_instr;
            out_pc    <= skid_pc;
            out_pc4   <= skid_pc + PC_STEP;
         end else if (resp_to_out) begin
            out_ce    <= 1'b1;
            out_instr <= f_i_imem_rdata;
            out_pc    <= req_pc;
            out_pc4   <= req_pc + PC_STEP;
         end else begin
            out_ce <= 1'b0;
         end
      end
   end

   assign f_o_imem_req  = req;
   assign f_o_imem_addr = fetch_pc;
   assign f_o_ce        = out_ce;
   assign f_o_instr     = out_instr;
   assign f_o_pc        = out_pc;
   assign f_o_pc_plus4  = out_pc4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a per-cycle vector table covering
// streaming, stall/skid, redirect and PC wrap, plus a hand sequence for a
// reset with a request in flight.
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        ce;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] pc_plus4;

   int unsigned n_cmp;
   int unsigned n_bad;
   logic        auto_mem;

   typedef struct {
      logic        stall;
      logic        redir;
      logic [31:0] rpc;
      logic        req;
      logic [31:0] addr;
      logic        ce;
      logic [31:0] instr;
      logic [31:0] pc;
   } vec_t;

   vec_t vecs[$];

   instr_fetch_unit #(
      .PC_WIDTH (32),
      .IWIDTH   (32),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .f_i_clk         (clk),
      .f_i_rst         (rst),
      .f_i_stall       (stall),
      .f_i_redirect    (redirect),
      .f_i_redirect_pc (redirect_pc),
      .f_o_imem_req    (imem_req),
      .f_o_imem_addr   (imem_addr),
      .f_i_imem_ack    (imem_ack),
      .f_i_imem_rvalid (imem_rvalid),
      .f_i_imem_rdata  (imem_rdata),
      .f_o_ce          (ce),
      .f_o_instr       (instr),
      .f_o_pc          (pc),
      .f_o_pc_plus4    (pc_plus4)
   );

   // free-running clock, 10 ns period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock from negedge to negedge; in auto mode the memory answers an
   // accepted request with rvalid on the following cycle, rdata = addr|0x2000_0000.
   task automatic run_cycle();
      logic        acc;
      logic [31:0] acc_addr;
      acc      = imem_req & imem_ack;
      acc_addr = imem_addr;
      @(posedge clk);
      #1;
      if (auto_mem) begin
         imem_rvalid = acc;
         imem_rdata  = acc ? (acc_addr | 32'h2000_0000) : 32'h0;
      end
      @(negedge clk);
   endtask

   function automatic void add(input logic s, input logic r, input logic [31:0] rp,
                               input logic q, input logic [31:0] a,
                               input logic c, input logic [31:0] i, input logic [31:0] p);
      vec_t v;
      v.stall = s; v.redir = r; v.rpc = rp;
      v.req = q; v.addr = a; v.ce = c; v.instr = i; v.pc = p;
      vecs.push_back(v);
   endfunction

   initial begin
      n_cmp       = 0;
      n_bad       = 0;
      auto_mem    = 1'b1;
      rst         = 1'b1;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      imem_ack    = 1'b1;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;

      //   stall redir rpc           req addr          ce instr         pc
      add(0, 0, 32'h0,        1, 32'h0000_0000, 0, 32'h0,        32'h0);          // first ack
      add(0, 0, 32'h0,        1, 32'h0000_0004, 1, 32'h2000_0000, 32'h0000_0000); // ce two edges after ack
      add(0, 0, 32'h0,        1, 32'h0000_0008, 1, 32'h2000_0004, 32'h0000_0004);
      add(0, 0, 32'h0,        1, 32'h0000_000C, 1, 32'h2000_0008, 32'h0000_0008);
      add(1, 0, 32'h0,        1'b0, 32'h0,      1, 32'h2000_0008, 32'h0000_0008); // 0x0C lands in skid
      add(1, 0, 32'h0,        1'b0, 32'h0,      1, 32'h2000_0008, 32'h0000_0008); // skid full, no req
      add(1, 0, 32'h0,        1'b0, 32'h0,      1, 32'h2000_0008, 32'h0000_0008);
      add(0, 0, 32'h0,        1'b0, 32'h0,      1, 32'h2000_000C, 32'h0000_000C); // skid drains
      add(0, 0, 32'h0,        1, 32'h0000_0010, 0, 32'h0,        32'h0);
      add(0, 0, 32'h0,        1, 32'h0000_0014, 1, 32'h2000_0010, 32'h0000_0010);
      add(0, 1, 32'h100,      1, 32'h0000_0018, 0, 32'h0,        32'h0);          // redirect, 0x14 data discarded
      add(0, 0, 32'h0,        0, 32'h0,         0, 32'h0,        32'h0);          // 0x18 dropped
      add(0, 0, 32'h0,        1, 32'h0000_0100, 0, 32'h0,        32'h0);
      add(0, 0, 32'h0,        1, 32'h0000_0104, 1, 32'h2000_0100, 32'h0000_0100);
      add(1, 1, 32'h100,      1, 32'h0000_0108, 0, 32'h0,        32'h0);          // redirect overrides stall
      add(0, 0, 32'h0,        0, 32'h0,         0, 32'h0,        32'h0);
      add(0, 0, 32'h0,        1, 32'h0000_0100, 0, 32'h0,        32'h0);
      add(0, 0, 32'h0,        1, 32'h0000_0104, 1, 32'h2000_0100, 32'h0000_0100);
      add(0, 1, 32'hFFFF_FFFC, 1, 32'h0000_0108, 0, 32'h0,       32'h0);          // redirect to top of space
      add(0, 0, 32'h0,        0, 32'h0,         0, 32'h0,        32'h0);
      add(0, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 32'h0,        32'h0);
      add(0, 0, 32'h0,        1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC); // pc_plus4 wraps to 0
      add(0, 0, 32'h0,        1, 32'h0000_0004, 1, 32'h2000_0000, 32'h0000_0000);

      // reset state
      @(negedge clk);
      #1 check("req_in_reset", {31'b0, imem_req}, 32'h0);
      run_cycle();
      run_cycle();
      check("rst_ce",    {31'b0, ce}, 32'h0);
      check("rst_instr", instr,       32'h0);
      check("rst_pc",    pc,          32'h0);
      check("rst_pc4",   pc_plus4,    32'h4);
      rst = 1'b0;

      // vector table
      foreach (vecs[k]) begin
         stall       = vecs[k].stall;
         redirect    = vecs[k].redir;
         redirect_pc = vecs[k].rpc;
         #1;
         check($sformatf("v%0d_req", k), {31'b0, imem_req}, {31'b0, vecs[k].req});
         if (vecs[k].req)
            check($sformatf("v%0d_addr", k), imem_addr, vecs[k].addr);
         run_cycle();
         check($sformatf("v%0d_ce", k), {31'b0, ce}, {31'b0, vecs[k].ce});
         if (vecs[k].ce) begin
            check($sformatf("v%0d_instr", k), instr,    vecs[k].instr);
            check($sformatf("v%0d_pc", k),    pc,       vecs[k].pc);
            check($sformatf("v%0d_pc4", k),   pc_plus4, vecs[k].pc + 32'd4);
         end
      end
      stall    = 1'b0;
      redirect = 1'b0;

      // reset while the fetch of 0x4 is in flight; its response arrives after reset
      auto_mem    = 1'b0;
      imem_rvalid = 1'b0;
      imem_ack    = 1'b0;
      rst         = 1'b1;
      #1 check("rs_req_in_reset", {31'b0, imem_req}, 32'h0);
      run_cycle();
      check("rs_ce",  {31'b0, ce}, 32'h0);
      check("rs_pc4", pc_plus4,    32'h4);

      rst         = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      #1 check("rs_req_restart", {31'b0, imem_req}, 32'h1);
      check("rs_addr_restart", imem_addr, 32'h0);
      run_cycle();
      check("rs_stale_ignored", {31'b0, ce}, 32'h0);

      imem_rvalid = 1'b0;
      imem_ack    = 1'b1;
      #1 check("rs_req_held", {31'b0, imem_req}, 32'h1);
      check("rs_addr_held", imem_addr, 32'h0);
      run_cycle();
      check("rs_ce_wait", {31'b0, ce}, 32'h0);

      imem_rvalid = 1'b1;
      imem_rdata  = 32'h2000_0000;
      imem_ack    = 1'b0;
      #1 check("rs_req_next", {31'b0, imem_req}, 32'h1);
      check("rs_addr_next", imem_addr, 32'h4);
      run_cycle();
      check("rs_ce",      {31'b0, ce}, 32'h1);
      check("rs_instr",   instr,       32'h2000_0000);
      check("rs_pc",      pc,          32'h0);
      check("rs_pc4_out", pc_plus4,    32'h4);
      imem_rvalid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
